// File: rtl/alu_if.sv
// Operand/result bundle for the ALU: operands and opcode in,
// combinational result and zero flag out, registered status flags out.
interface alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUCtrl;
    logic [31:0] Y;
    logic        ZERO;
    logic [3:0]  FLAGS;

    modport master (
        output A,
        output B,
        output ALUCtrl,
        input  Y,
        input  ZERO,
        input  FLAGS
    );

    modport slave (
        input  A,
        input  B,
        input  ALUCtrl,
        output Y,
        output ZERO,
        output FLAGS
    );
endinterface

// File: rtl/alu.sv
// 32-bit ALU: combinational result/zero, plus a status-flag register
// {N,Z,C,V} capturing the previous cycle's operation.
module alu (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_NOR  = 4'b1100
    } op_e;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] y;
    logic        zero;
    logic        c;
    logic        v;
    logic [3:0]  flags_d;
    logic [3:0]  flags_q;

    assign a     = bus.A;
    assign b     = bus.B;
    assign shamt = bus.B[4:0];

    // Widened by one bit so carry-out / borrow fall out directly.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = 32'h0;
        c = 1'b0;
        v = 1'b0;
        unique case (bus.ALUCtrl)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_ADD: begin
                y = sum[31:0];
                c = sum[32];
                v = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                y = diff[31:0];
                c = ~diff[32];
                v = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_SLTU: y = {31'h0, diff[32]};
            OP_SLT:  y = {31'h0, $signed(a) < $signed(b)};
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            default: y = 32'h0;
        endcase
    end

    assign zero     = (y == 32'h0);
    assign flags_d  = {y[31], zero, c, v};

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.Y     = y;
    assign bus.ZERO  = zero;
    assign bus.FLAGS = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: driver queues expected results,
// monitor checks Y/ZERO each cycle and FLAGS one edge later.
module tb_alu;

    logic clk;
    logic rst;

    alu_if ifc ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] y;
        logic        z;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    bit   have_prev;
    logic [3:0] prev_f;
    logic [3:0] prev_op;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic r,
                         input logic [31:0] ey, input logic ez,
                         input logic [3:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        ifc.ALUCtrl = op;
        ifc.A       = a;
        ifc.B       = b;
        rst         = r;
        e.op = op;
        e.y  = ey;
        e.z  = ez;
        e.f  = ef;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                checks++;
                if (ifc.FLAGS !== prev_f) begin
                    errors++;
                    $display("FAIL flags op=%b: got %b want %b",
                             prev_op, ifc.FLAGS, prev_f);
                end
                have_prev = 1'b0;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (ifc.Y !== e.y) begin
                    errors++;
                    $display("FAIL Y op=%b: got %h want %h",
                             e.op, ifc.Y, e.y);
                end
                checks++;
                if (ifc.ZERO !== e.z) begin
                    errors++;
                    $display("FAIL ZERO op=%b: got %b want %b",
                             e.op, ifc.ZERO, e.z);
                end
                prev_f    = e.f;
                prev_op   = e.op;
                have_prev = 1'b1;
            end
        end
    end

    initial begin : driver
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        ifc.A       = 32'h0;
        ifc.B       = 32'h0;
        ifc.ALUCtrl = 4'b0000;
        //    op       A             B             rst   Y             Z     FLAGS
        issue(4'b0000, 32'h1000_0000, 32'h1000_0000, 1'b1, 32'h1000_0000, 1'b0, 4'b0000);
        issue(4'b0000, 32'h1000_0000, 32'h1000_0000, 1'b0, 32'h1000_0000, 1'b0, 4'b0000);
        issue(4'b0001, 32'h1000_0000, 32'h0000_1000, 1'b0, 32'h1000_1000, 1'b0, 4'b0000);
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4'b0110);
        issue(4'b0110, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 4'b0110);
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 4'b0011);
        issue(4'b0111, 32'h0000_1000, 32'h1000_0000, 1'b0, 32'h0000_0001, 1'b0, 4'b0000);
        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 4'b0000);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4'b0100);
        issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0, 1'b0, 4'b0000);
        issue(4'b0100, 32'h0000_0001, 32'h0000_001F, 1'b0, 32'h8000_0000, 1'b0, 4'b1000);
        issue(4'b0100, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 32'h1234_5678, 1'b0, 4'b0000);
        issue(4'b0101, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000, 1'b0, 4'b0000);
        issue(4'b1000, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'hF800_0000, 1'b0, 4'b1000);
        issue(4'b1000, 32'h7FFF_FFF0, 32'h0000_0024, 1'b0, 32'h07FF_FFFF, 1'b0, 4'b0000);
        issue(4'b1100, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b1000);
        issue(4'b1111, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 4'b0100);
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 4'b1001);
        issue(4'b0110, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b1000);
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0, 4'b0010);
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 1'b0, 4'b0000);
        issue(4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 4'b0100);
        issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 4'b0100);
        issue(4'b0010, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 4'b0111);
        issue(4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 4'b0100);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0 || have_prev) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single clock; rising edge samples the status-flag register only.
REQ-002 rst  input  1  synchronous, active-high reset; acts only on a rising clk edge while high.
REQ-003 A  input  32  operand A.
REQ-004 B  input  32  operand B; shift amount = B[4:0].
REQ-005 ALUCtrl  input  4  operation select.
REQ-006 Y  output  32  combinational result.
REQ-007 ZERO  output  1  combinational; high when Y == 32'h0.
REQ-008 FLAGS  output  4  registered status {N,Z,C,V} of the previous cycle's operation.

Function
REQ-009 Y and ZERO SHALL be purely combinational from A, B and ALUCtrl, with no clock dependency.
REQ-010 Y and ZERO SHALL settle within one clock period of an input change; no latches anywhere.
REQ-011 Operation encoding:
- 0000 AND: A & B.
- 0001 OR: A | B.
- 0010 ADD: A + B, mod 2^32.
- 0110 SUB: A - B, mod 2^32 (two's complement).
- 0111 SLTU: 32'h1 if A < B unsigned, else 0.
- 0011 XOR: A ^ B.
- 0100 SLL: A << B[4:0].
- 0101 SRL: A >> B[4:0], logical.
- 1000 SRA: A >>> B[4:0], arithmetic; sign of A[31] replicated.
- 1001 SLT: 32'h1 if A < B signed, else 0.
- 1100 NOR: ~(A | B).
REQ-012 Any other ALUCtrl code SHALL give Y = 32'h0 and ZERO = 1.
REQ-013 ZERO SHALL equal (Y == 0) for every code, including the SLT/SLTU results.
REQ-014 ADD: C = carry-out of bit 31; V = (A[31] == B[31]) && (Y[31] != A[31]).
REQ-015 SUB: C = no-borrow, i.e. 1 when A >= B unsigned; V = (A[31] != B[31]) && (Y[31] != A[31]).
REQ-016 All codes other than ADD/SUB SHALL set C = 0 and V = 0.
REQ-017 N SHALL be Y[31] and Z SHALL be ZERO for every code.
REQ-018 Each rising clk edge with rst low SHALL load FLAGS with the current {N,Z,C,V}.
REQ-019 FLAGS SHALL be observable one edge after the inputs were presented.
REQ-020 Shift amount 0 SHALL return A unchanged; B[31:5] SHALL be ignored for all shifts.
REQ-021 Operands SHALL be accepted every cycle; there is no handshake and no stall.

Reset
REQ-022 rst high at a rising clk edge SHALL clear FLAGS to 4'b0000.
REQ-023 Reset SHALL have no effect on Y or ZERO, which keep tracking the inputs during reset.
REQ-024 Deasserting rst SHALL resume flag capture at the next rising edge; no recovery cycles.

Verification
REQ-025 AND with A = B = 32'h1000_0000 -> Y = 32'h1000_0000, ZERO = 0.
REQ-026 OR with A = 32'h1000_0000, B = 32'h0000_1000 -> Y = 32'h1000_1000, ZERO = 0.
REQ-027 ADD with A = 32'hFFFF_FFFF, B = 32'h1 -> Y = 0, ZERO = 1; after the next edge FLAGS = 4'b0110.
REQ-028 SUB with A = B = 32'h1234_5678 -> Y = 0, ZERO = 1.
REQ-029 SUB with A = 32'h8000_0000, B = 32'h1 -> Y = 32'h7FFF_FFFF; after the next edge FLAGS = 4'b0011.
REQ-030 SLTU with A = 32'h0000_1000, B = 32'h1000_0000 -> Y = 1.
REQ-031 SLT with A = 32'hFFFF_FFFF, B = 32'h1 -> Y = 1; SLTU with the same operands -> Y = 0, ZERO = 1.
REQ-032 rst held high across one edge after an ADD with carry -> FLAGS = 0, while Y still shows the ADD result.
